// File: rtl/keccak_pkg.sv
// Shared constants, types and helpers for the masked Keccak absorb path.
// Geometry below describes one rate block split into shares and lanes.
package keccak_pkg;

  localparam int RATE          = 1088;
  localparam int W             = 64;
  localparam int SHARES        = 2;
  localparam int ABSORB_LANES  = 17;
  localparam int ABSORB_SLICES = 1;

  localparam int LANES   = RATE / W;
  localparam int GROUPS  = LANES / ABSORB_LANES;
  localparam int SGROUPS = W / ABSORB_SLICES;
  localparam int NBYTES  = W / 8;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IW  = cw(LANES);
  localparam int SW  = cw(SGROUPS);
  localparam int GW  = cw(GROUPS);
  localparam int WIW = cw(W);
  localparam int BW  = $clog2(NBYTES + 1);
  localparam int OW  = SHARES * ABSORB_LANES * ABSORB_SLICES;

  typedef logic [W-1:0] Lane_t;
  typedef logic [LANES-1:0][W-1:0] PadMask_t;
  typedef logic [SHARES-1:0][LANES-1:0][W-1:0] SharedBlock_t;

  typedef enum logic [1:0] {
    FILL,
    ISSUE,
    DONE
  } State_t;

  // Byte-enable mask keeping the lowest n bytes of a lane.
  function automatic Lane_t keepBytes(input logic [BW-1:0] n);
    Lane_t m;
    m = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if (k < int'(n)) m[8*k +: 8] = 8'hFF;
    end
    return m;
  endfunction

endpackage

// File: rtl/keccak_absorb_sequencer_pad_gen.sv
// Share-0 pad10*1 XOR mask for the block holding the final lane.
// Pad-only mode yields the mask for a block that carries no message bytes.
module keccak_pad_gen
  import keccak_pkg::*;
#(
  parameter logic [7:0] DS_BYTE = 8'h06
) (
  input  logic [IW-1:0] LastIdxxDI,
  input  logic [BW-1:0] BytesxDI,
  input  logic          PadOnlyxSI,
  output PadMask_t      PadMaskxDO,
  output logic          RoomxSO
);

  int dsLane;
  int dsByte;

  // Locate the first free byte and place DS there, 0x80 at the block end.
  always_comb begin
    RoomxSO = (int'(BytesxDI) < NBYTES) ||
              (int'(LastIdxxDI) < LANES - 1);
    dsLane = int'(LastIdxxDI);
    dsByte = int'(BytesxDI);
    if (PadOnlyxSI) begin
      dsLane = 0;
      dsByte = 0;
    end else if (int'(BytesxDI) >= NBYTES) begin
      dsLane = int'(LastIdxxDI) + 1;
      dsByte = 0;
    end
    PadMaskxDO = '0;
    if (PadOnlyxSI || RoomxSO) begin
      for (int l = 0; l < LANES; l++) begin
        for (int k = 0; k < NBYTES; k++) begin
          if (l == dsLane && k == dsByte)
            PadMaskxDO[l][8*k +: 8] = DS_BYTE;
        end
      end
      PadMaskxDO[LANES-1][W-1 -: 8] =
        PadMaskxDO[LANES-1][W-1 -: 8] ^ 8'h80;
    end
  end

endmodule

// File: rtl/keccak_absorb_sequencer.sv
// Buffers one masked rate block, pads share 0 and feeds the DOM core
// slice groups (slices inner, lane groups outer) over StartAbsorb/Ready.
module keccak_absorb_sequencer
  import keccak_pkg::*;
#(
  parameter bit         PAD_EN  = 1'b1,
  parameter logic [7:0] DS_BYTE = 8'h06
) (
  input  logic                ClkxCI,
  input  logic                RstxRI,
  input  logic [SHARES*W-1:0] InLanexDI,
  input  logic                InValidxSI,
  input  logic                InLastxSI,
  input  logic [BW-1:0]       InBytesxDI,
  output logic                InReadyxSO,
  output logic                StartAbsorbxSO,
  input  logic                ReadyxSI,
  output logic [OW-1:0]       AbsorbSlicesxDO,
  output logic                BlockDonexSO,
  output logic                MsgDonexSO
);

  State_t       statexDP, statexDN;
  logic [IW-1:0] laneCntxDP, laneCntxDN;
  logic [SW-1:0] sCntxDP, sCntxDN;
  logic [GW-1:0] gCntxDP, gCntxDN;
  logic         finalxSP, finalxSN;
  logic         padPendxSP, padPendxSN;
  SharedBlock_t bufxDP, bufxDN;
  PadMask_t     padMask;
  logic         roomxS;
  Lane_t        keepMask;
  logic [IW-1:0] laneSel;
  logic [WIW-1:0] sBase;

  keccak_pad_gen #(
    .DS_BYTE(DS_BYTE)
  ) i_pad (
    .LastIdxxDI(laneCntxDP),
    .BytesxDI  (InBytesxDI),
    .PadOnlyxSI(padPendxSP),
    .PadMaskxDO(padMask),
    .RoomxSO   (roomxS)
  );

  // Registers: state, counters, flags and the shared block buffer.
  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      statexDP   <= FILL;
      laneCntxDP <= '0;
      sCntxDP    <= '0;
      gCntxDP    <= '0;
      finalxSP   <= 1'b0;
      padPendxSP <= 1'b0;
      bufxDP     <= '0;
    end else begin
      statexDP   <= statexDN;
      laneCntxDP <= laneCntxDN;
      sCntxDP    <= sCntxDN;
      gCntxDP    <= gCntxDN;
      finalxSP   <= finalxSN;
      padPendxSP <= padPendxSN;
      bufxDP     <= bufxDN;
    end
  end

  // Next-state, buffer update and handshake outputs.
  always_comb begin
    statexDN        = statexDP;
    laneCntxDN      = laneCntxDP;
    sCntxDN         = sCntxDP;
    gCntxDN         = gCntxDP;
    finalxSN        = finalxSP;
    padPendxSN      = padPendxSP;
    bufxDN          = bufxDP;
    InReadyxSO      = 1'b0;
    StartAbsorbxSO  = 1'b0;
    AbsorbSlicesxDO = '0;
    BlockDonexSO    = 1'b0;
    MsgDonexSO      = 1'b0;
    laneSel         = '0;
    sBase           = '0;
    keepMask        = keepBytes(InBytesxDI);
    unique case (statexDP)
      FILL: begin
        InReadyxSO = 1'b1;
        if (InValidxSI) begin
          for (int i = 0; i < SHARES; i++)
            bufxDN[i][laneCntxDP] = InLanexDI[i*W +: W];
          if (InLastxSI) begin
            for (int i = 0; i < SHARES; i++) begin
              for (int l = 0; l < LANES; l++) begin
                if (l > int'(laneCntxDP))
                  bufxDN[i][l] = '0;
                else if (l == int'(laneCntxDP))
                  bufxDN[i][l] = InLanexDI[i*W +: W] & keepMask;
              end
            end
            statexDN = ISSUE;
            if (PAD_EN && roomxS) begin
              bufxDN[0] = bufxDN[0] ^ padMask;
              finalxSN  = 1'b1;
            end else if (PAD_EN) begin
              padPendxSN = 1'b1;
            end else begin
              finalxSN = 1'b1;
            end
          end else if (int'(laneCntxDP) == LANES - 1) begin
            statexDN = ISSUE;
          end else begin
            laneCntxDN = laneCntxDP + 1'b1;
          end
        end
      end
      ISSUE: begin
        StartAbsorbxSO = 1'b1;
        sBase = WIW'(int'(sCntxDP) * ABSORB_SLICES);
        for (int i = 0; i < SHARES; i++) begin
          for (int j = 0; j < ABSORB_LANES; j++) begin
            laneSel = IW'(int'(gCntxDP) * ABSORB_LANES + j);
            AbsorbSlicesxDO[(i*ABSORB_LANES+j)*ABSORB_SLICES +: ABSORB_SLICES] =
              bufxDP[i][laneSel][sBase +: ABSORB_SLICES];
          end
        end
        if (ReadyxSI) begin
          if (sCntxDP == SW'(SGROUPS - 1)) begin
            sCntxDN = '0;
            if (gCntxDP == GW'(GROUPS - 1)) begin
              gCntxDN  = '0;
              statexDN = DONE;
            end else begin
              gCntxDN = gCntxDP + 1'b1;
            end
          end else begin
            sCntxDN = sCntxDP + 1'b1;
          end
        end
      end
      DONE: begin
        BlockDonexSO = 1'b1;
        MsgDonexSO   = finalxSP;
        bufxDN       = '0;
        laneCntxDN   = '0;
        sCntxDN      = '0;
        gCntxDN      = '0;
        if (padPendxSP) begin
          bufxDN[0]  = padMask;
          finalxSN   = 1'b1;
          padPendxSN = 1'b0;
          statexDN   = ISSUE;
        end else begin
          finalxSN = 1'b0;
          statexDN = FILL;
        end
      end
      default: statexDN = FILL;
    endcase
  end

endmodule

// File: tb/tb_keccak_absorb_sequencer.sv
// Bench for the absorb sequencer: byte-stream pad10*1 model per share,
// table of padding corner cases, a mid-transfer reset and random messages.
module tb_keccak_absorb_sequencer;
  import keccak_pkg::*;

  localparam int RB   = RATE / 8;
  localparam int MAXL = 64;
  localparam int MAXB = 4 * RB;
  localparam logic [7:0] DS = 8'h06;

  logic                ClkxCI = 1'b0;
  logic                RstxRI;
  logic [SHARES*W-1:0] InLanexDI;
  logic                InValidxSI;
  logic                InLastxSI;
  logic [BW-1:0]       InBytesxDI;
  logic                InReadyxSO;
  logic                StartAbsorbxSO;
  logic                ReadyxSI;
  logic [OW-1:0]       AbsorbSlicesxDO;
  logic                BlockDonexSO;
  logic                MsgDonexSO;

  int checks = 0;
  int failures = 0;

  keccak_absorb_sequencer #(
    .PAD_EN (1'b1),
    .DS_BYTE(DS)
  ) dut (
    .ClkxCI         (ClkxCI),
    .RstxRI         (RstxRI),
    .InLanexDI      (InLanexDI),
    .InValidxSI     (InValidxSI),
    .InLastxSI      (InLastxSI),
    .InBytesxDI     (InBytesxDI),
    .InReadyxSO     (InReadyxSO),
    .StartAbsorbxSO (StartAbsorbxSO),
    .ReadyxSI       (ReadyxSI),
    .AbsorbSlicesxDO(AbsorbSlicesxDO),
    .BlockDonexSO   (BlockDonexSO),
    .MsgDonexSO     (MsgDonexSO)
  );

  always #5 ClkxCI = ~ClkxCI;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic runMsg(input int nLanes, input int lastBytes,
                        input int readyPct, input bit zeroMsg,
                        input int abortAt, output PadMask_t rec,
                        output int nSeen);
    Lane_t        ml [SHARES][MAXL];
    logic [7:0]   mb [SHARES][MAXB];
    SharedBlock_t cap;
    Lane_t        r, e;
    logic [OW-1:0] prevData;
    int L, P, nBlk, li, xfer, g, s, cyc, blk;
    bit done, prevStall;
    rec = '0;
    nSeen = 0;
    for (int l = 0; l < nLanes; l++) begin
      r = '0;
      for (int sh = 1; sh < SHARES; sh++) begin
        ml[sh][l] = {$urandom, $urandom};
        r = r ^ ml[sh][l];
      end
      ml[0][l] = zeroMsg ? r : Lane_t'({$urandom, $urandom});
    end
    L = (nLanes - 1) * NBYTES + lastBytes;
    P = (L / RB + 1) * RB;
    nBlk = P / RB;
    for (int sh = 0; sh < SHARES; sh++)
      for (int b = 0; b < MAXB; b++)
        mb[sh][b] = (b < L) ? ml[sh][b/NBYTES][8*(b%NBYTES) +: 8] : 8'h00;
    mb[0][L]   = mb[0][L] ^ DS;
    mb[0][P-1] = mb[0][P-1] ^ 8'h80;

    cap = '0;
    li = 0; xfer = 0; g = 0; s = 0; cyc = 0; blk = 0;
    done = 1'b0; prevStall = 1'b0; prevData = '0;
    while (!done && cyc < 4000) begin
      @(negedge ClkxCI);
      cyc++;
      if (prevStall) begin
        chk("stall_hold", 64'(StartAbsorbxSO), 64'd1);
        chk("stall_data", 64'(AbsorbSlicesxDO), 64'(prevData));
      end
      if (StartAbsorbxSO) chk("inready_in_issue", 64'(InReadyxSO), 64'd0);
      if (MsgDonexSO && !BlockDonexSO) chk("msgdone_alone", 64'd1, 64'd0);
      if (BlockDonexSO) begin
        if (blk >= nBlk) begin
          chk("extra_block", 64'(blk), 64'(nBlk - 1));
          done = 1'b1;
        end else begin
          for (int sh = 0; sh < SHARES; sh++) begin
            for (int l = 0; l < LANES; l++) begin
              for (int k = 0; k < NBYTES; k++)
                e[8*k +: 8] = mb[sh][blk*RB + l*NBYTES + k];
              chk($sformatf("blk%0d_sh%0d_lane%0d", blk, sh, l),
                  cap[sh][l], e);
            end
          end
          chk("xfer_count", 64'(xfer), 64'(GROUPS * SGROUPS));
          chk("msgdone", 64'(MsgDonexSO), 64'(blk == nBlk - 1));
          for (int l = 0; l < LANES; l++) begin
            r = '0;
            for (int sh = 0; sh < SHARES; sh++) r = r ^ cap[sh][l];
            rec[l] = r;
          end
          blk++;
          nSeen = blk;
          xfer = 0; g = 0; s = 0;
          cap = '0;
          if (blk == nBlk) done = 1'b1;
        end
      end
      InValidxSI = (li < nLanes) && !done && ($urandom_range(0, 99) < 80);
      InLastxSI  = (li == nLanes - 1);
      InBytesxDI = InLastxSI ? BW'(lastBytes)
                             : BW'($urandom_range(0, NBYTES));
      for (int sh = 0; sh < SHARES; sh++)
        InLanexDI[sh*W +: W] = (li < nLanes) ? ml[sh][li] : '0;
      ReadyxSI = ($urandom_range(0, 99) < readyPct);
      if (abortAt >= 0 && StartAbsorbxSO && xfer == abortAt) begin
        RstxRI = 1'b1;
        InValidxSI = 1'b0;
        ReadyxSI = 1'b0;
        @(negedge ClkxCI);
        RstxRI = 1'b0;
        chk("rst_start", 64'(StartAbsorbxSO), 64'd0);
        chk("rst_inready", 64'(InReadyxSO), 64'd1);
        chk("rst_blockdone", 64'(BlockDonexSO), 64'd0);
        chk("rst_msgdone", 64'(MsgDonexSO), 64'd0);
        chk("rst_data", 64'(AbsorbSlicesxDO), 64'd0);
        return;
      end
      if (InValidxSI && InReadyxSO) li++;
      if (StartAbsorbxSO && ReadyxSI) begin
        for (int sh = 0; sh < SHARES; sh++)
          for (int j = 0; j < ABSORB_LANES; j++)
            cap[sh][g*ABSORB_LANES+j][s*ABSORB_SLICES +: ABSORB_SLICES] =
              AbsorbSlicesxDO[(sh*ABSORB_LANES+j)*ABSORB_SLICES +: ABSORB_SLICES];
        xfer++;
        if (s == SGROUPS - 1) begin
          s = 0;
          g++;
        end else begin
          s++;
        end
      end
      prevStall = StartAbsorbxSO && !ReadyxSI;
      prevData  = AbsorbSlicesxDO;
    end
    if (!done) chk("timeout", 64'(cyc), 64'd0);
    InValidxSI = 1'b0;
    ReadyxSI = 1'b0;
  endtask

  typedef struct {
    int          nLanes;
    int          lastBytes;
    int          readyPct;
    int          expBlocks;
    int          dsLane;
    logic [63:0] dsVal;
    logic [63:0] lastLane;
  } vec_t;

  vec_t     tbl[6];
  PadMask_t rec;
  int       nb;
  Lane_t    ex;

  initial begin
    tbl[0] = '{1,  0, 100, 1, 0,  64'h06, 64'h8000_0000_0000_0000};
    tbl[1] = '{17, 8, 100, 2, 0,  64'h06, 64'h8000_0000_0000_0000};
    tbl[2] = '{17, 7, 100, 1, 16, 64'h8600_0000_0000_0000,
               64'h8600_0000_0000_0000};
    tbl[3] = '{1,  0, 30,  1, 0,  64'h06, 64'h8000_0000_0000_0000};
    tbl[4] = '{3,  3, 60,  1, 2,  64'h0000_0000_0600_0000,
               64'h8000_0000_0000_0000};
    tbl[5] = '{1,  8, 100, 1, 1,  64'h06, 64'h8000_0000_0000_0000};

    RstxRI = 1'b1;
    InLanexDI = '0;
    InValidxSI = 1'b0;
    InLastxSI = 1'b0;
    InBytesxDI = '0;
    ReadyxSI = 1'b0;
    repeat (2) @(negedge ClkxCI);
    RstxRI = 1'b0;
    chk("reset_inready", 64'(InReadyxSO), 64'd1);
    chk("reset_start", 64'(StartAbsorbxSO), 64'd0);
    chk("reset_data", 64'(AbsorbSlicesxDO), 64'd0);
    chk("reset_blockdone", 64'(BlockDonexSO), 64'd0);
    chk("reset_msgdone", 64'(MsgDonexSO), 64'd0);

    runMsg(1, 0, 100, 1'b0, 20, rec, nb);

    for (int t = 0; t < 6; t++) begin
      runMsg(tbl[t].nLanes, tbl[t].lastBytes, tbl[t].readyPct, 1'b1,
             -1, rec, nb);
      chk($sformatf("tbl%0d_blocks", t), 64'(nb), 64'(tbl[t].expBlocks));
      for (int l = 0; l < LANES; l++) begin
        ex = (l == tbl[t].dsLane) ? tbl[t].dsVal :
             (l == LANES - 1) ? tbl[t].lastLane : 64'd0;
        chk($sformatf("tbl%0d_lane%0d", t, l), rec[l], ex);
      end
    end

    for (int t = 0; t < 20; t++) begin
      runMsg($urandom_range(1, 50), $urandom_range(0, NBYTES),
             $urandom_range(30, 100), 1'b0, -1, rec, nb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
